// File: rtl/pixel_stream_decoder_pkg.sv
// Shared word coding for the 17-bit pixel queue protocol. The pattern
// generator on the writer side imports the same package so both ends agree
// on marker values and coordinate widths.
package StreamProtocol;

  localparam int WORD_W  = 17;
  localparam int COORD_W = 11;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [15:0]        rgb565_t;

  // Bit 16 set marks a control word; only these three values are meaningful.
  localparam word_t FS = 17'h10000;
  localparam word_t RS = 17'h10001;
  localparam word_t FE = 17'h1FFFF;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    WAIT_ROW   = 2'd1,
    PIXELS     = 2'd2
  } decoder_state_t;

  // Counters stick at all-ones so an absurdly long row or frame cannot wrap
  // back into the valid coordinate range.
  function automatic coord_t satInc(input coord_t v);
    return (v == '1) ? v : coord_t'(v + 1'b1);
  endfunction

endpackage

// File: rtl/pixel_stream_decoder_if.sv
// Valid/ready pixel stream from the decoder toward the frame-buffer writer
// or LCD path. The decoder drives the master side.
interface pixel_stream_decoder_if;
  import StreamProtocol::*;

  logic    pix_valid;
  logic    pix_ready;
  rgb565_t pix_data;
  coord_t  pix_x;
  coord_t  pix_y;

  modport master (
    output pix_valid,
    output pix_data,
    output pix_x,
    output pix_y,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_data,
    input  pix_x,
    input  pix_y,
    output pix_ready
  );

endinterface

// File: rtl/pixel_stream_decoder_prefetch.sv
// Two-entry prefetch buffer in front of the decoder. The external FIFO has a
// one-cycle read latency, so one read may be in flight; reads are only issued
// while the buffer is guaranteed to have room for every returned word.
module stream_prefetch_fifo
  import StreamProtocol::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  queue_empty,
  output logic  queue_rd_en,
  input  word_t queue_data,
  input  logic  pop_i,
  output logic  headValid_o,
  output word_t headWord_o
);

  word_t      mem_q [2];
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       pending_q;
  logic       wrPtr_q;
  logic       rdPtr_q;
  logic       popEff;
  logic [2:0] inFlight;

  // Occupancy is counted after this cycle's pop so a steady stream can keep
  // one word buffered and one in flight, sustaining one word per cycle.
  always_comb begin
    popEff      = pop_i && (count_q != 2'd0);
    inFlight    = {1'b0, count_q} - {2'b0, popEff} + {2'b0, pending_q};
    queue_rd_en = !queue_empty && (inFlight < 3'd2);
    count_d     = count_q + {1'b0, pending_q} - {1'b0, popEff};
    headValid_o = (count_q != 2'd0);
    headWord_o  = mem_q[rdPtr_q];
  end

  // Every word returned by the FIFO lands in the buffer; pointers ping-pong.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      count_q   <= 2'd0;
      pending_q <= 1'b0;
      wrPtr_q   <= 1'b0;
      rdPtr_q   <= 1'b0;
    end else begin
      if (pending_q) begin
        mem_q[wrPtr_q] <= queue_data;
        wrPtr_q        <= ~wrPtr_q;
      end
      if (popEff) begin
        rdPtr_q <= ~rdPtr_q;
      end
      count_q   <= count_d;
      pending_q <= queue_rd_en;
    end
  end

endmodule

// File: rtl/pixel_stream_decoder.sv
// Reader end of the pixel queue: decodes frame/row markers, tracks (x, y),
// emits RGB565 pixels through a single output register and flags malformed
// rows and frames. Resynchronises on the next frame-start marker.
module pixel_stream_decoder
  import StreamProtocol::*;
#(
  parameter int FRAME_WIDTH  = 480,
  parameter int FRAME_HEIGHT = 272
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  queue_empty,
  output logic  queue_rd_en,
  input  word_t queue_data,
  pixel_stream_decoder_if.master pix,
  output logic  frame_start,
  output logic  frame_done,
  output logic  err_row_len,
  output logic  err_frame
);

  localparam coord_t WIDTH_C  = coord_t'(FRAME_WIDTH);
  localparam coord_t HEIGHT_C = coord_t'(FRAME_HEIGHT);

  decoder_state_t state_q, state_d;
  coord_t  row_q, row_d;
  coord_t  col_q, col_d;
  coord_t  rowAfter;
  logic    outValid_q;
  rgb565_t outData_q;
  coord_t  outX_q, outY_q;
  logic    frameStart_q, frameDone_q, errRowLen_q, errFrame_q;
  logic    headValid;
  word_t   headWord;
  logic    canTake, consume;
  logic    emit, fsPulse, fdPulse, rowErr, frameErr;

  stream_prefetch_fifo prefetch (
    .clk         (clk),
    .reset_n     (reset_n),
    .queue_empty (queue_empty),
    .queue_rd_en (queue_rd_en),
    .queue_data  (queue_data),
    .pop_i       (consume),
    .headValid_o (headValid),
    .headWord_o  (headWord)
  );

  // Any word, pixel or marker, is taken only when the output register can
  // move, so frame_done never overtakes the final pixel.
  always_comb begin
    canTake = !outValid_q || pix.pix_ready;
    consume = headValid && canTake;
  end

  // Decode one word per cycle: next state, counters and event pulses.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    rowAfter = row_q;
    emit     = 1'b0;
    fsPulse  = 1'b0;
    fdPulse  = 1'b0;
    rowErr   = 1'b0;
    frameErr = 1'b0;
    if (consume) begin
      if (!headWord[16]) begin
        if (state_q == WAIT_ROW) begin
          frameErr = 1'b1;
        end else if (state_q == PIXELS) begin
          emit  = (col_q < WIDTH_C) && (row_q < HEIGHT_C);
          col_d = satInc(col_q);
        end
      end else if (headWord == FS) begin
        fsPulse  = 1'b1;
        frameErr = (state_q != WAIT_FRAME);
        row_d    = '0;
        col_d    = '0;
        state_d  = WAIT_ROW;
      end else if ((headWord == RS) || (headWord == FE)) begin
        if (state_q != WAIT_FRAME) begin
          if (state_q == PIXELS) begin
            rowErr   = (col_q != WIDTH_C);
            rowAfter = satInc(row_q);
          end
          row_d = rowAfter;
          if (headWord == RS) begin
            col_d   = '0;
            state_d = PIXELS;
          end else begin
            frameErr = (rowAfter != HEIGHT_C);
            fdPulse  = 1'b1;
            state_d  = WAIT_FRAME;
          end
        end
      end else begin
        frameErr = 1'b1;
      end
    end
  end

  // Decoder state and coordinate counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_FRAME;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Output register: loads on emit, clears once accepted, otherwise holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outX_q     <= '0;
      outY_q     <= '0;
    end else if (emit) begin
      outValid_q <= 1'b1;
      outData_q  <= headWord[15:0];
      outX_q     <= col_q;
      outY_q     <= row_q;
    end else if (pix.pix_ready) begin
      outValid_q <= 1'b0;
    end
  end

  // Registered single-cycle event pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frameStart_q <= 1'b0;
      frameDone_q  <= 1'b0;
      errRowLen_q  <= 1'b0;
      errFrame_q   <= 1'b0;
    end else begin
      frameStart_q <= fsPulse;
      frameDone_q  <= fdPulse;
      errRowLen_q  <= rowErr;
      errFrame_q   <= frameErr;
    end
  end

  assign pix.pix_valid = outValid_q;
  assign pix.pix_data  = outData_q;
  assign pix.pix_x     = outX_q;
  assign pix.pix_y     = outY_q;
  assign frame_start   = frameStart_q;
  assign frame_done    = frameDone_q;
  assign err_row_len   = errRowLen_q;
  assign err_frame     = errFrame_q;

endmodule

// File: tb/tb_pixel_stream_decoder.sv
// Bench for pixel_stream_decoder on a reduced 8x4 frame. A FIFO model feeds
// queued words with one-cycle read latency; a scoreboard of expected pixels
// is filled as words are queued and drained as the DUT hands pixels over.
module tb_pixel_stream_decoder;
  import StreamProtocol::*;

  localparam int TW = 8;
  localparam int TH = 4;

  logic  clk = 1'b0;
  logic  reset_n;
  logic  queue_empty;
  logic  queue_rd_en;
  word_t queue_data;
  logic  frame_start, frame_done, err_row_len, err_frame;

  pixel_stream_decoder_if pixIf();

  pixel_stream_decoder #(.FRAME_WIDTH(TW), .FRAME_HEIGHT(TH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .queue_empty (queue_empty),
    .queue_rd_en (queue_rd_en),
    .queue_data  (queue_data),
    .pix         (pixIf),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .err_row_len (err_row_len),
    .err_frame   (err_frame)
  );

  always #5 clk = ~clk;

  word_t       srcQ[$];
  logic [37:0] expQ[$];
  int checks = 0;
  int errors = 0;
  bit inReset = 1'b1;
  bit randReady = 1'b0;
  bit randEmpty = 1'b0;
  bit holdReady = 1'b0;
  int cyc = 0;
  int lastFall = -1;
  int validRise = -1;
  int lastAcc = -1;
  logic [21:0] lastPix = '0;
  int fsCnt = 0, fdCnt = 0, erlCnt = 0, efCnt = 0;
  int fsBase = 0, fdBase = 0, erlBase = 0, efBase = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input word_t w);
    srcQ.push_back(w);
  endtask

  function automatic rgb565_t pixData(input int seed, input int x, input int y);
    return rgb565_t'(seed * 40503 + y * 257 + x * 13);
  endfunction

  // Queue a row start plus n pixels; pixels inside the frame are expected out.
  task automatic sendRow(input int seed, input int y, input int n);
    rgb565_t d;
    applyStimulus(RS);
    for (int x = 0; x < n; x++) begin
      d = pixData(seed, x, y);
      applyStimulus({1'b0, d});
      if (x < TW && y < TH) expQ.push_back({d, coord_t'(x), coord_t'(y)});
    end
  endtask

  task automatic sendFrame(input int seed);
    applyStimulus(FS);
    for (int y = 0; y < TH; y++) sendRow(seed, y, TW);
    applyStimulus(FE);
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while ((srcQ.size() != 0 || expQ.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_drain_timeout"}, 64'(n >= 3000), 0);
    repeat (8) @(negedge clk);
  endtask

  task automatic checkPulses(input string tag, input int efs, input int efd, input int erl, input int ef);
    checkOutput({tag, "_frame_start"}, 64'(fsCnt - fsBase), 64'(efs));
    checkOutput({tag, "_frame_done"}, 64'(fdCnt - fdBase), 64'(efd));
    checkOutput({tag, "_err_row_len"}, 64'(erlCnt - erlBase), 64'(erl));
    checkOutput({tag, "_err_frame"}, 64'(efCnt - efBase), 64'(ef));
    fsBase = fsCnt; fdBase = fdCnt; erlBase = erlCnt; efBase = efCnt;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_pix_valid"}, pixIf.pix_valid, 0);
    checkOutput({tag, "_pix_data"}, pixIf.pix_data, 0);
    checkOutput({tag, "_pix_x"}, pixIf.pix_x, 0);
    checkOutput({tag, "_pix_y"}, pixIf.pix_y, 0);
    checkOutput({tag, "_frame_start"}, frame_start, 0);
    checkOutput({tag, "_frame_done"}, frame_done, 0);
    checkOutput({tag, "_err_row_len"}, err_row_len, 0);
    checkOutput({tag, "_err_frame"}, err_frame, 0);
    checkOutput({tag, "_queue_rd_en"}, queue_rd_en, 0);
  endtask

  // FIFO model, downstream sink and output monitor. Inputs change on the
  // falling edge; outputs are sampled 1 time unit before the rising edge.
  initial begin
    word_t       nextWord = '0;
    bit          haveNext = 1'b0;
    bit          prevStall = 1'b0;
    bit          prevValid = 1'b0;
    bit          prevEmpty = 1'b1;
    logic [37:0] heldPix = '0;
    logic [37:0] exp;
    queue_empty = 1'b1;
    queue_data = '0;
    pixIf.pix_ready = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (inReset) begin
        queue_empty = 1'b1;
        pixIf.pix_ready = 1'b0;
        haveNext = 1'b0;
        prevStall = 1'b0;
        prevValid = 1'b0;
        prevEmpty = 1'b1;
      end else begin
        if (haveNext) begin
          queue_data = nextWord;
          haveNext = 1'b0;
        end
        pixIf.pix_ready = holdReady ? 1'b0 : (randReady ? 1'($urandom_range(0, 1)) : 1'b1);
        queue_empty = (srcQ.size() == 0) || (randEmpty && ($urandom_range(0, 1) == 0));
        if (prevEmpty && !queue_empty) lastFall = cyc;
        prevEmpty = queue_empty;
        #4;
        if (!inReset) begin
          if (queue_rd_en) begin
            checkOutput("fifo_underflow", queue_empty, 0);
            if (!queue_empty && srcQ.size() > 0) begin
              nextWord = srcQ.pop_front();
              haveNext = 1'b1;
            end
          end
          if (prevStall)
            checkOutput("stall_hold", {pixIf.pix_valid, pixIf.pix_data, pixIf.pix_x, pixIf.pix_y}, {1'b1, heldPix});
          if (pixIf.pix_valid && pixIf.pix_ready) begin
            if (expQ.size() == 0) begin
              checkOutput("unexpected_pixel", 1, 0);
            end else begin
              exp = expQ.pop_front();
              checkOutput("pixel", {pixIf.pix_data, pixIf.pix_x, pixIf.pix_y}, exp);
            end
            lastAcc = cyc;
            lastPix = {pixIf.pix_x, pixIf.pix_y};
          end
          prevStall = pixIf.pix_valid && !pixIf.pix_ready;
          heldPix = {pixIf.pix_data, pixIf.pix_x, pixIf.pix_y};
          if (pixIf.pix_valid && !prevValid) validRise = cyc;
          prevValid = pixIf.pix_valid;
          fsCnt += int'(frame_start);
          fdCnt += int'(frame_done);
          erlCnt += int'(err_row_len);
          efCnt += int'(err_frame);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t0;
    int n;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checkResetOutputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    inReset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] full frame");
    t0 = cyc;
    sendFrame(1);
    waitIdle("full");
    checkPulses("full", 1, 1, 0, 0);
    checkOutput("full_last_xy", lastPix, {coord_t'(TW - 1), coord_t'(TH - 1)});
    checkOutput("full_throughput", 64'((lastAcc - t0) <= TW * TH + 2 * TH + 8), 1);

    $display("[TB] short row");
    applyStimulus(FS);
    sendRow(2, 0, TW - 1);
    for (int y = 1; y < TH; y++) sendRow(2, y, TW);
    applyStimulus(FE);
    waitIdle("short");
    checkPulses("short", 1, 1, 1, 0);

    $display("[TB] long row");
    applyStimulus(FS);
    sendRow(3, 0, TW + 1);
    for (int y = 1; y < TH; y++) sendRow(3, y, TW);
    applyStimulus(FE);
    waitIdle("long");
    checkPulses("long", 1, 1, 1, 0);

    $display("[TB] premature frame start");
    applyStimulus(FS);
    sendRow(4, 0, TW);
    sendRow(4, 1, TW);
    sendFrame(5);
    waitIdle("early_fs");
    checkPulses("early_fs", 2, 1, 0, 1);

    $display("[TB] random ready and empty");
    randReady = 1'b1;
    randEmpty = 1'b1;
    sendFrame(6);
    sendFrame(7);
    waitIdle("random");
    checkPulses("random", 2, 2, 0, 0);
    randReady = 1'b0;
    randEmpty = 1'b0;

    $display("[TB] unknown marker mid-row");
    applyStimulus(FS);
    applyStimulus(RS);
    for (int x = 0; x < TW; x++) begin
      if (x == 3) applyStimulus(17'h12345);
      applyStimulus({1'b0, pixData(8, x, 0)});
      expQ.push_back({pixData(8, x, 0), coord_t'(x), coord_t'(0)});
    end
    for (int y = 1; y < TH; y++) sendRow(8, y, TW);
    applyStimulus(FE);
    waitIdle("unknown");
    checkPulses("unknown", 1, 1, 0, 1);

    $display("[TB] first pixel latency");
    applyStimulus(FS);
    applyStimulus(RS);
    waitIdle("latency_setup");
    t0 = cyc;
    applyStimulus({1'b0, pixData(9, 0, 0)});
    expQ.push_back({pixData(9, 0, 0), coord_t'(0), coord_t'(0)});
    n = 0;
    while (validRise <= t0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("latency", 64'(validRise > lastFall && lastFall >= t0 && (validRise - lastFall) <= 3), 1);
    for (int x = 1; x < TW; x++) begin
      applyStimulus({1'b0, pixData(9, x, 0)});
      expQ.push_back({pixData(9, x, 0), coord_t'(x), coord_t'(0)});
    end
    for (int y = 1; y < TH; y++) sendRow(9, y, TW);
    applyStimulus(FE);
    waitIdle("latency");
    checkPulses("latency", 1, 1, 0, 0);

    $display("[TB] stall then reset mid-row");
    applyStimulus(FS);
    sendRow(10, 0, 3);
    waitIdle("pre_reset");
    checkPulses("pre_reset", 1, 0, 0, 0);
    holdReady = 1'b1;
    for (int x = 3; x < 8; x++) applyStimulus({1'b0, pixData(10, x, 0)});
    repeat (12) @(negedge clk);
    #2;
    checkOutput("stall_valid", pixIf.pix_valid, 1);
    checkOutput("stall_rd_en", queue_rd_en, 0);
    checkOutput("stall_fetched", 64'(srcQ.size()), 2);
    @(negedge clk);
    inReset = 1'b1;
    reset_n = 1'b0;
    srcQ.delete();
    expQ.delete();
    repeat (2) @(negedge clk);
    #2;
    checkResetOutputs("mid_reset");
    @(negedge clk);
    holdReady = 1'b0;
    reset_n = 1'b1;
    inReset = 1'b0;
    applyStimulus({1'b0, pixData(11, 0, 0)});
    applyStimulus(RS);
    applyStimulus({1'b0, pixData(11, 1, 0)});
    applyStimulus(FE);
    sendFrame(12);
    waitIdle("post_reset");
    checkPulses("post_reset", 1, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
